// File: rtl/airi5c_icap_seq_if.sv
// AHB-Lite bus bundle for the ICAP sequencer register window.
// Ports (slave view): haddr/hwrite/hsize/hburst/hmastlock/hprot/htrans/hwdata in,
// hrdata/hready/hresp out. The master modport is the mirror image.
interface airi5c_icap_seq_if;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hmastlock;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic [1:0]  hresp;

    modport master (
        output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/airi5c_icap_seq.sv
// ICAPE2 partial-reconfiguration sequencer with an AHB-Lite register window.
// Streams sync preamble, FIFO-buffered payload and desync postamble into ICAPE2.
// Ports:
//   clk, n_reset          clock, asynchronous active-low reset
//   bus (slave)           AHB-Lite register access (CTRL/STATUS/DATA/COUNT)
//   icap_i                ICAPE2 I data, each byte bit-reversed
//   icap_csib             ICAPE2 CSIB, active low
//   icap_rdwrb            ICAPE2 RDWRB, tied to write
//   lock                  high while a sequence is in progress
//   irq                   done interrupt (DONE sticky and IRQ_EN)
module airi5c_icap_seq #(
    parameter logic [31:0] BASE_ADDR  = 32'hC000_0070,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 n_reset,
    airi5c_icap_seq_if.slave     bus,
    output logic [31:0]          icap_i,
    output logic                 icap_csib,
    output logic                 icap_rdwrb,
    output logic                 lock,
    output logic                 irq
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_STREAM,
        S_POST,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        phase_q;

    logic              wr_q;
    logic [1:0]        addr_q;

    logic              irq_en_q, irq_en_n;
    logic              done_q, done_n;
    logic              aborted_q, aborted_n;
    logic              ovf_q, ovf_n;
    logic [15:0]       count_q;
    logic [15:0]       remaining_q;

    logic [31:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q;
    logic [LVL_W-1:0]  level_q;

    logic              sel_c, start_c, abort_c, abort_hit_c, ctrl_wr_c;
    logic              stat_clr_c, push_c, push_ok_c, count_wr_c;
    logic              fifo_full_c, fifo_empty_c;
    logic              drive_c, pop_c;
    logic [31:0]       word_c;
    logic [31:0]       rd_mux_c;

    // Reverse bit order inside each byte of a word.
    function automatic logic [31:0] byte_bit_swap(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 8; k++) begin
                r[8*b + k] = w[8*b + 7 - k];
            end
        end
        return r;
    endfunction

    assign bus.hready = 1'b1;
    assign bus.hresp  = 2'b00;
    assign icap_rdwrb = 1'b0;

    // AHB address-phase decode and data-phase strobes.
    assign sel_c        = (bus.htrans != 2'b00) && (bus.haddr[31:4] == BASE_ADDR[31:4]);
    assign ctrl_wr_c    = wr_q && (addr_q == 2'd0);
    assign start_c      = ctrl_wr_c && bus.hwdata[0];
    assign abort_c      = ctrl_wr_c && bus.hwdata[1];
    assign stat_clr_c   = wr_q && (addr_q == 2'd1) && bus.hwdata[1];
    assign push_c       = wr_q && (addr_q == 2'd2);
    assign count_wr_c   = wr_q && (addr_q == 2'd3) && (state_q == S_IDLE);
    assign abort_hit_c  = abort_c && ((state_q == S_PRE) || (state_q == S_STREAM));

    assign fifo_full_c  = (level_q == LVL_W'(FIFO_DEPTH));
    assign fifo_empty_c = (level_q == '0);
    // A full FIFO still accepts a push when the same cycle pops.
    assign push_ok_c    = push_c && (!fifo_full_c || pop_c);

    // Read mux, sampled in the address phase.
    always_comb begin
        rd_mux_c = 32'h0;
        case (bus.haddr[3:2])
            2'd0: rd_mux_c = {29'h0, irq_en_q, 2'b00};
            2'd1: rd_mux_c = {remaining_q, 8'h00, 4'(level_q), ovf_q, aborted_q, done_q,
                              (state_q != S_IDLE)};
            2'd3: rd_mux_c = {16'h0, count_q};
            default: rd_mux_c = 32'h0;
        endcase
    end

    // AHB pipeline registers and read data.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_q       <= 1'b0;
            addr_q     <= 2'd0;
            bus.hrdata <= 32'h0;
        end else begin
            wr_q       <= sel_c && bus.hwrite;
            addr_q     <= bus.haddr[3:2];
            bus.hrdata <= (sel_c && !bus.hwrite) ? rd_mux_c : 32'h0;
        end
    end

    // FSM state register; phase counts cycles within PRE/POST.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= S_IDLE;
            phase_q <= 2'd0;
        end else begin
            state_q <= state_d;
            phase_q <= (state_d != state_q) ? 2'd0 : phase_q + 2'd1;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_c && (count_q != 16'd0)) state_d = S_PRE;
            S_PRE: begin
                if (abort_c)               state_d = S_POST;
                else if (phase_q == 2'd2)  state_d = S_STREAM;
            end
            S_STREAM: begin
                if (abort_c)                                       state_d = S_POST;
                else if (!fifo_empty_c && (remaining_q == 16'd1))  state_d = S_POST;
            end
            S_POST:   if (phase_q == 2'd3) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: word selection and FIFO pop.
    always_comb begin
        drive_c = 1'b0;
        pop_c   = 1'b0;
        word_c  = 32'h0;
        case (state_q)
            S_PRE: begin
                drive_c = 1'b1;
                case (phase_q)
                    2'd0:    word_c = 32'hFFFF_FFFF;
                    2'd1:    word_c = 32'hAA99_5566;
                    default: word_c = 32'h2000_0000;
                endcase
            end
            S_STREAM: begin
                // Empty FIFO pauses the stream with CSIB high and I held.
                if (!fifo_empty_c) begin
                    drive_c = 1'b1;
                    pop_c   = 1'b1;
                    word_c  = mem[rptr_q];
                end
            end
            S_POST: begin
                drive_c = 1'b1;
                case (phase_q)
                    2'd0:    word_c = 32'h3000_8001;
                    2'd1:    word_c = 32'h0000_000D;
                    default: word_c = 32'h2000_0000;
                endcase
            end
            default: ;
        endcase
    end

    // ICAP output registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            icap_i    <= 32'h0;
            icap_csib <= 1'b1;
        end else begin
            if (drive_c) icap_i <= byte_bit_swap(word_c);
            icap_csib <= !drive_c;
        end
    end

    // Next values of the control/status flags; sets win over a same-cycle clear.
    always_comb begin
        irq_en_n  = ctrl_wr_c ? bus.hwdata[2] : irq_en_q;
        done_n    = done_q;
        aborted_n = aborted_q;
        ovf_n     = ovf_q;
        if (stat_clr_c) begin
            done_n    = 1'b0;
            aborted_n = 1'b0;
            ovf_n     = 1'b0;
        end
        if ((state_q == S_DONE) || ((state_q == S_IDLE) && start_c && (count_q == 16'd0)))
            done_n = 1'b1;
        if (abort_hit_c)
            aborted_n = 1'b1;
        if (push_c && !push_ok_c)
            ovf_n = 1'b1;
    end

    // Control/status registers, counters and registered lock/irq.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            irq_en_q    <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            ovf_q       <= 1'b0;
            count_q     <= 16'd0;
            remaining_q <= 16'd0;
            lock        <= 1'b0;
            irq         <= 1'b0;
        end else begin
            irq_en_q  <= irq_en_n;
            done_q    <= done_n;
            aborted_q <= aborted_n;
            ovf_q     <= ovf_n;
            lock      <= (state_d != S_IDLE);
            irq       <= done_n && irq_en_n;
            if (count_wr_c) count_q <= bus.hwdata[15:0];
            if ((state_q == S_IDLE) && start_c && (count_q != 16'd0))
                remaining_q <= count_q;
            else if (pop_c)
                remaining_q <= remaining_q - 16'd1;
        end
    end

    // FIFO pointers and level; an accepted abort flushes all entries.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (abort_hit_c) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_ok_c) wptr_q <= wptr_q + PTR_W'(1);
            if (pop_c)     rptr_q <= rptr_q + PTR_W'(1);
            case ({push_ok_c, pop_c})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // FIFO storage, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok_c && !abort_hit_c) mem[wptr_q] <= bus.hwdata;
    end

endmodule

// File: tb/tb_airi5c_icap_seq.sv
// Directed self-checking bench for airi5c_icap_seq.
module tb_airi5c_icap_seq;

    localparam logic [31:0] A_CTRL = 32'hC000_0070;
    localparam logic [31:0] A_STAT = 32'hC000_0074;
    localparam logic [31:0] A_DATA = 32'hC000_0078;
    localparam logic [31:0] A_CNT  = 32'hC000_007C;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [31:0] icap_i;
    logic        icap_csib, icap_rdwrb, lock, irq;

    airi5c_icap_seq_if bus();

    airi5c_icap_seq dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .bus        (bus),
        .icap_i     (icap_i),
        .icap_csib  (icap_csib),
        .icap_rdwrb (icap_rdwrb),
        .lock       (lock),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] cap [$];
    int          run_cur = 0;
    int          run_max = 0;

    logic [31:0] post_sw [4] = '{32'h0C00_0180, 32'h0000_00B0, 32'h0400_0000, 32'h0400_0000};

    // Record every word presented with CSIB low, and the longest CSIB-low run.
    always @(negedge clk) begin
        if (n_reset && icap_csib === 1'b0) begin
            cap.push_back(icap_i);
            run_cur = run_cur + 1;
            if (run_cur > run_max) run_max = run_cur;
        end else begin
            run_cur = 0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        bus.haddr  = a;
        bus.htrans = 2'b10;
        bus.hwrite = 1'b1;
        @(posedge clk);
        #1;
        bus.htrans = 2'b00;
        bus.hwrite = 1'b0;
        bus.hwdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        bus.haddr  = a;
        bus.htrans = 2'b10;
        bus.hwrite = 1'b0;
        @(posedge clk);
        #1;
        bus.htrans = 2'b00;
        d = bus.hrdata;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!lock) break;
            cycles(1);
        end
        vectors++;
        if (lock !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: lock still %b after %0d cycles, want 0", lock, budget);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        vectors++;
        if ({icap_csib, lock, irq, icap_rdwrb} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_pins: csib/lock/irq/rdwrb=%b want 1000",
                     {icap_csib, lock, irq, icap_rdwrb});
        end
        vectors++;
        if (icap_i !== 32'h0) begin
            errors++;
            $display("FAIL reset_icap_i: got %h want 00000000", icap_i);
        end
        vectors++;
        if ({bus.hready, bus.hresp} !== 3'b100) begin
            errors++;
            $display("FAIL reset_hready_hresp: got %b want 100", {bus.hready, bus.hresp});
        end
        bus_rd(A_STAT, d);
        vectors++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_status: got %h want 00000000", d);
        end
        bus_rd(A_CNT, d);
        vectors++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL reset_count: got %h want 00000000", d);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic [31:0] exp_w [9] = '{32'hFFFF_FFFF, 32'h5599_AA66, 32'h0400_0000,
                                   32'h8844_CC22, 32'hAA66_EE11, 32'h0C00_0180,
                                   32'h0000_00B0, 32'h0400_0000, 32'h0400_0000};
        bus_wr(A_CTRL, 32'h4);
        bus_wr(A_DATA, 32'h1122_3344);
        bus_wr(A_DATA, 32'h5566_7788);
        bus_wr(A_CNT, 32'h2);
        cap.delete();
        run_max = 0;
        bus_wr(A_CTRL, 32'h5);
        wait_idle(40);
        vectors++;
        if (cap.size() !== 9) begin
            errors++;
            $display("FAIL basic_word_count: got %0d want 9", cap.size());
        end
        for (int i = 0; i < 9; i++) begin
            vectors++;
            if (i >= cap.size() || cap[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL basic_word[%0d]: got %h want %h", i,
                         (i < cap.size()) ? cap[i] : 32'hx, exp_w[i]);
            end
        end
        vectors++;
        if (run_max !== 9) begin
            errors++;
            $display("FAIL basic_csib_run: got %0d want 9", run_max);
        end
        bus_rd(A_STAT, d);
        vectors++;
        if (d !== 32'h0000_0002) begin
            errors++;
            $display("FAIL basic_status: got %h want 00000002", d);
        end
        vectors++;
        if (irq !== 1'b1) begin
            errors++;
            $display("FAIL basic_irq: got %b want 1", irq);
        end
        bus_rd(A_CTRL, d);
        vectors++;
        if (d !== 32'h0000_0004) begin
            errors++;
            $display("FAIL basic_ctrl_readback: got %h want 00000004", d);
        end
        bus_wr(A_STAT, 32'h2);
        vectors++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL basic_irq_clear: got %b want 0", irq);
        end
    endtask

    task automatic test_count_zero();
        logic [31:0] d;
        bus_wr(A_CNT, 32'h0);
        cap.delete();
        bus_wr(A_CTRL, 32'h1);
        cycles(5);
        vectors++;
        if (cap.size() !== 0 || lock !== 1'b0) begin
            errors++;
            $display("FAIL count0_no_sequence: words %0d lock %b want 0 0", cap.size(), lock);
        end
        bus_rd(A_STAT, d);
        vectors++;
        if (d !== 32'h0000_0002) begin
            errors++;
            $display("FAIL count0_status: got %h want 00000002", d);
        end
        bus_wr(A_STAT, 32'h2);
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [31:0] exp_p [8] = '{32'h80, 32'h40, 32'hC0, 32'h20, 32'hA0, 32'h60, 32'hE0, 32'h10};
        int found;
        for (int i = 1; i <= 9; i++) bus_wr(A_DATA, 32'(i));
        bus_rd(A_STAT, d);
        vectors++;
        if (d !== 32'h0000_0088) begin
            errors++;
            $display("FAIL ovf_status: got %h want 00000088", d);
        end
        bus_wr(A_CNT, 32'h8);
        cap.delete();
        bus_wr(A_CTRL, 32'h1);
        wait_idle(60);
        vectors++;
        if (cap.size() !== 15) begin
            errors++;
            $display("FAIL ovf_word_count: got %0d want 15", cap.size());
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (i + 3 >= cap.size() || cap[i+3] !== exp_p[i]) begin
                errors++;
                $display("FAIL ovf_payload[%0d]: got %h want %h", i,
                         (i + 3 < cap.size()) ? cap[i+3] : 32'hx, exp_p[i]);
            end
        end
        found = 0;
        foreach (cap[i]) if (cap[i] === 32'h0000_0090) found++;
        vectors++;
        if (found !== 0) begin
            errors++;
            $display("FAIL ovf_dropped_word: seen %0d times want 0", found);
        end
        bus_rd(A_STAT, d);
        vectors++;
        if (d !== 32'h0000_000A) begin
            errors++;
            $display("FAIL ovf_status_after: got %h want 0000000a", d);
        end
        bus_wr(A_STAT, 32'h2);
    endtask

    task automatic test_pause();
        logic [31:0] d;
        bus_wr(A_DATA, 32'h1);
        bus_wr(A_CNT, 32'h3);
        cap.delete();
        bus_wr(A_CTRL, 32'h1);
        cycles(12);
        vectors++;
        if (cap.size() !== 4 || icap_csib !== 1'b1 || lock !== 1'b1) begin
            errors++;
            $display("FAIL pause_stall: words %0d csib %b lock %b want 4 1 1",
                     cap.size(), icap_csib, lock);
        end
        bus_rd(A_STAT, d);
        vectors++;
        if (d !== 32'h0002_0001) begin
            errors++;
            $display("FAIL pause_status: got %h want 00020001", d);
        end
        bus_wr(A_CNT, 32'h55);
        bus_rd(A_CNT, d);
        vectors++;
        if (d !== 32'h0000_0003) begin
            errors++;
            $display("FAIL busy_count_write: got %h want 00000003", d);
        end
        bus_wr(A_DATA, 32'h2);
        bus_wr(A_DATA, 32'h3);
        wait_idle(40);
        vectors++;
        if (cap.size() !== 10) begin
            errors++;
            $display("FAIL pause_word_count: got %0d want 10", cap.size());
        end else begin
            vectors++;
            if ({cap[3], cap[4], cap[5], cap[6]} !==
                {32'h80, 32'h40, 32'hC0, 32'h0C00_0180}) begin
                errors++;
                $display("FAIL pause_resume_words: got %h %h %h %h want 80 40 c0 0c000180",
                         cap[3], cap[4], cap[5], cap[6]);
            end
        end
        bus_wr(A_STAT, 32'h2);
    endtask

    task automatic test_abort_stream();
        logic [31:0] d;
        bus_wr(A_DATA, 32'h1);
        bus_wr(A_DATA, 32'h2);
        bus_wr(A_CNT, 32'h5);
        cap.delete();
        bus_wr(A_CTRL, 32'h1);
        cycles(12);
        bus_wr(A_CTRL, 32'h2);
        wait_idle(30);
        vectors++;
        if (cap.size() !== 9) begin
            errors++;
            $display("FAIL abort_stream_count: got %0d want 9", cap.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (cap[5+i] !== post_sw[i]) begin
                    errors++;
                    $display("FAIL abort_stream_post[%0d]: got %h want %h", i, cap[5+i], post_sw[i]);
                end
            end
        end
        bus_rd(A_STAT, d);
        vectors++;
        if (d !== 32'h0003_0006) begin
            errors++;
            $display("FAIL abort_stream_status: got %h want 00030006", d);
        end
        bus_wr(A_STAT, 32'h2);
    endtask

    task automatic test_abort_pre();
        logic [31:0] d;
        bus_wr(A_DATA, 32'h1);
        bus_wr(A_DATA, 32'h2);
        bus_wr(A_DATA, 32'h3);
        bus_wr(A_CNT, 32'h3);
        cap.delete();
        bus_wr(A_CTRL, 32'h1);
        bus_wr(A_CTRL, 32'h2);
        wait_idle(30);
        vectors++;
        if (cap.size() !== 6) begin
            errors++;
            $display("FAIL abort_pre_count: got %0d want 6", cap.size());
        end else begin
            vectors++;
            if ({cap[0], cap[1], cap[2], cap[5]} !==
                {32'hFFFF_FFFF, 32'h5599_AA66, post_sw[0], post_sw[3]}) begin
                errors++;
                $display("FAIL abort_pre_words: got %h %h %h %h", cap[0], cap[1], cap[2], cap[5]);
            end
        end
        bus_rd(A_STAT, d);
        vectors++;
        if (d !== 32'h0003_0006) begin
            errors++;
            $display("FAIL abort_pre_status_flush: got %h want 00030006", d);
        end
        bus_wr(A_STAT, 32'h2);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bus_wr(A_CTRL, 32'h4);
        bus_wr(A_DATA, 32'h1);
        bus_wr(A_CNT, 32'h1);
        bus_wr(A_CTRL, 32'h5);
        cycles(1);
        vectors++;
        if (icap_csib !== 1'b0 || lock !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre_active: csib %b lock %b want 0 1", icap_csib, lock);
        end
        n_reset = 1'b0;
        #1;
        vectors++;
        if (icap_csib !== 1'b1 || lock !== 1'b0 || icap_i !== 32'h0) begin
            errors++;
            $display("FAIL midreset_immediate: csib %b lock %b icap_i %h want 1 0 00000000",
                     icap_csib, lock, icap_i);
        end
        #2;
        n_reset = 1'b1;
        cycles(1);
        bus_rd(A_CTRL, d);
        vectors++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL midreset_ctrl: got %h want 00000000", d);
        end
        bus_rd(A_STAT, d);
        vectors++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL midreset_status: got %h want 00000000", d);
        end
        bus_rd(A_CNT, d);
        vectors++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL midreset_count: got %h want 00000000", d);
        end
    endtask

    initial begin
        bus.haddr     = 32'h0;
        bus.hwrite    = 1'b0;
        bus.hsize     = 3'b010;
        bus.hburst    = 3'b000;
        bus.hmastlock = 1'b0;
        bus.hprot     = 4'h0;
        bus.htrans    = 2'b00;
        bus.hwdata    = 32'h0;
        #23;
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_count_zero();
        test_overflow();
        test_pause();
        test_abort_stream();
        test_abort_pre();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
